stream_upsizer: RTL and testbench
=================================

STREAM_UPSIZER -- requirements
Module: stream_upsizer

Interface
REQ-001: Parameter WIDTH_IN, default 8, width in bits of one input beat (>=1).
REQ-002: Parameter RATIO, default 4, input beats packed per output word (>=2; need not be a power of two).
REQ-003: Parameter type T_OUT, default logic [WIDTH_IN*RATIO-1:0], output word type.
REQ-004: Port clk_i, input, 1, single clock; all state rising-edge.
REQ-005: Port rst_ni, input, 1, asynchronous active-low reset.
REQ-006: Port clr_i, input, 1, synchronous clear, active high.
REQ-007: Port in_data_i, input, WIDTH_IN, input beat payload.
REQ-008: Port in_last_i, input, 1, beat closes the current word early (packet end).
REQ-009: Port in_valid_i, input, 1, input beat valid.
REQ-010: Port in_ready_o, output, 1, block accepts beat this cycle.
REQ-011: Port out_data_o, output, WIDTH_IN*RATIO, packed word; slot k occupies bits [k*WIDTH_IN +: WIDTH_IN].
REQ-012: Port out_mask_o, output, RATIO, bit k set when slot k holds a valid beat.
REQ-013: Port out_last_o, output, 1, word was closed by in_last_i.
REQ-014: Port out_valid_o, output, 1, output word valid.
REQ-015: Port out_ready_i, input, 1, downstream accepts word.

Function
REQ-016: Beat transfer occurs when in_valid_i & in_ready_o; word transfer when out_valid_o & out_ready_i.
REQ-017: Internal slot counter cnt, width $clog2(RATIO), range 0..RATIO-1; accepted beat is written to accumulator slot cnt.
REQ-018: A beat is "completing" when cnt == RATIO-1 or in_last_i == 1; otherwise "filling".
REQ-019: Filling beat: accumulator slot cnt <= in_data_i, cnt <= cnt+1, output register untouched.
REQ-020: Completing beat: output register <= accumulator slots 0..cnt-1 plus in_data_i in slot cnt, slots above cnt zero; out_mask_o <= bits [cnt:0] set, rest clear; out_last_o <= in_last_i; out_valid_o <= 1; cnt <= 0; accumulator cleared.
REQ-021: in_ready_o = !(in_valid_i & completing) | !out_valid_o | out_ready_i; filling beats never stall; combinational path out_ready_i -> in_ready_o permitted.
REQ-022: Latency: word visible on out_* exactly one cycle after its completing beat is accepted.
REQ-023: Throughput: one beat per cycle sustained when out_ready_i held high; no bubble between consecutive words.
REQ-024: Word transfer without simultaneous completing beat: out_valid_o <= 0 next cycle; out_data_o/out_mask_o/out_last_o hold value.
REQ-025: Simultaneous word transfer and completing beat: new word loaded, out_valid_o stays 1.
REQ-026: While out_valid_o & !out_ready_i, out_data_o, out_mask_o, out_last_o shall remain stable.
REQ-027: in_last_i on first beat (cnt==0) yields a word with out_mask_o = 1 (single slot).
REQ-028: in_last_i on beat cnt==RATIO-1 yields full mask and out_last_o = 1.
REQ-029: Output shall not depend combinationally on in_data_i/in_valid_i (registered output).
REQ-030: clr_i high: next edge cnt <= 0, accumulator cleared, out_valid_o <= 0; in_ready_o forced 0 and no transfer counted that cycle.

Reset
REQ-031: On rst_ni low, asynchronously: cnt = 0, accumulator = 0, out_data_o = 0, out_mask_o = 0, out_last_o = 0, out_valid_o = 0.
REQ-032: Reset mid-word discards partially filled accumulator; first beat after release lands in slot 0.

Verification (WIDTH_IN=8, RATIO=4)
REQ-033: Beats 0x11,0x22,0x33,0x44 back-to-back, out_ready_i=1 -> one cycle after 4th beat: out_data_o=0x44332211, mask=4'b1111, last=0, valid for one cycle.
REQ-034: Beats 0xAA,0xBB(last) -> out_data_o=0x0000BBAA, mask=4'b0011, last=1; following beat goes to slot 0.
REQ-035: 8 beats continuous, out_ready_i=0 after first word -> in_ready_o drops only on 8th (completing) beat; first word held stable; raise out_ready_i -> 8th accepted same cycle, second word follows next cycle.
REQ-036: Single beat 0x5A with last -> out_data_o=0x0000005A, mask=4'b0001, last=1.
REQ-037: Two beats accepted, then clr_i pulse, then 4 beats 0x01..0x04 -> single word 0x04030201, mask 4'b1111; no residue of earlier beats.
REQ-038: Assert rst_ni low mid-word with out_valid_o=1 -> all outputs 0 immediately, asynchronously.

Source files
------------

// File: rtl/stream_upsizer.sv
// Packs RATIO narrow input beats into one wide output word, with early close on in_last_i.
// The output word sits in a register stage that can be refilled in the same cycle it is consumed.
module stream_upsizer #(
  parameter int unsigned WIDTH_IN = 8,
  parameter int unsigned RATIO    = 4,
  parameter type         T_OUT    = logic [WIDTH_IN*RATIO-1:0]
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clr_i,
  input  logic [WIDTH_IN-1:0] in_data_i,
  input  logic                in_last_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  output T_OUT                out_data_o,
  output logic [RATIO-1:0]    out_mask_o,
  output logic                out_last_o,
  output logic                out_valid_o,
  input  logic                out_ready_i
);

  localparam int unsigned      OUT_W   = WIDTH_IN * RATIO;
  localparam int unsigned      CNT_W   = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0] cnt_r,  cnt_nxt_s;
  logic [OUT_W-1:0] acc_r,  acc_nxt_s;
  logic [OUT_W-1:0] data_r, data_nxt_s;
  logic [RATIO-1:0] mask_r, mask_nxt_s;
  logic             last_r, last_nxt_s;
  logic             valid_r, valid_nxt_s;
  logic             completing_s;
  logic             beat_xfer_s;
  logic             word_xfer_s;
  logic [OUT_W-1:0] word_s;
  logic [RATIO-1:0] word_mask_s;

  // Handshake: a completing beat may only enter when the output register is free or draining.
  always_comb begin
    completing_s = (cnt_r == CNT_MAX) | in_last_i;
    in_ready_o   = ~clr_i & (~(in_valid_i & completing_s) | ~valid_r | out_ready_i);
    beat_xfer_s  = in_valid_i & in_ready_o;
    word_xfer_s  = valid_r & out_ready_i;
  end

  // Candidate output word: stored slots below cnt, the incoming beat at cnt, zeros above.
  always_comb begin
    word_s      = {OUT_W{1'b0}};
    word_mask_s = {RATIO{1'b0}};
    for (int k = 0; k < RATIO; k++) begin
      if (CNT_W'(k) == cnt_r) begin
        word_s[k*WIDTH_IN +: WIDTH_IN] = in_data_i;
        word_mask_s[k]                 = 1'b1;
      end else if (CNT_W'(k) < cnt_r) begin
        word_s[k*WIDTH_IN +: WIDTH_IN] = acc_r[k*WIDTH_IN +: WIDTH_IN];
        word_mask_s[k]                 = 1'b1;
      end else begin
        word_s[k*WIDTH_IN +: WIDTH_IN] = {WIDTH_IN{1'b0}};
        word_mask_s[k]                 = 1'b0;
      end
    end
  end

  // Next-state selection for counter, accumulator and output register.
  always_comb begin
    cnt_nxt_s   = cnt_r;
    acc_nxt_s   = acc_r;
    data_nxt_s  = data_r;
    mask_nxt_s  = mask_r;
    last_nxt_s  = last_r;
    valid_nxt_s = valid_r;
    if (clr_i) begin
      cnt_nxt_s   = {CNT_W{1'b0}};
      acc_nxt_s   = {OUT_W{1'b0}};
      valid_nxt_s = 1'b0;
    end else if (beat_xfer_s && completing_s) begin
      cnt_nxt_s   = {CNT_W{1'b0}};
      acc_nxt_s   = {OUT_W{1'b0}};
      data_nxt_s  = word_s;
      mask_nxt_s  = word_mask_s;
      last_nxt_s  = in_last_i;
      valid_nxt_s = 1'b1;
    end else begin
      if (beat_xfer_s) begin
        cnt_nxt_s = cnt_r + CNT_W'(1);
        for (int k = 0; k < RATIO; k++) begin
          if (CNT_W'(k) == cnt_r) begin
            acc_nxt_s[k*WIDTH_IN +: WIDTH_IN] = in_data_i;
          end else begin
            acc_nxt_s[k*WIDTH_IN +: WIDTH_IN] = acc_r[k*WIDTH_IN +: WIDTH_IN];
          end
        end
      end else begin
        cnt_nxt_s = cnt_r;
      end
      if (word_xfer_s) begin
        valid_nxt_s = 1'b0;
      end else begin
        valid_nxt_s = valid_r;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_r   <= {CNT_W{1'b0}};
      acc_r   <= {OUT_W{1'b0}};
      data_r  <= {OUT_W{1'b0}};
      mask_r  <= {RATIO{1'b0}};
      last_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      cnt_r   <= cnt_nxt_s;
      acc_r   <= acc_nxt_s;
      data_r  <= data_nxt_s;
      mask_r  <= mask_nxt_s;
      last_r  <= last_nxt_s;
      valid_r <= valid_nxt_s;
    end
  end

  assign out_data_o  = T_OUT'(data_r);
  assign out_mask_o  = mask_r;
  assign out_last_o  = last_r;
  assign out_valid_o = valid_r;

endmodule

// File: tb/tb_stream_upsizer.sv
// Self-checking bench for stream_upsizer (WIDTH_IN=8, RATIO=4): directed cases plus
// randomized traffic compared cycle by cycle against a queue-based packing model.
module tb_stream_upsizer;

  localparam int W = 8;
  localparam int R = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_mask;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: beats gathered for the open word, and the word on the output.
  logic [7:0]  cur[$];
  logic [31:0] m_data;
  logic [3:0]  m_mask;
  logic        m_last;
  logic        m_valid;
  logic        acc_flag;

  stream_upsizer #(.WIDTH_IN(W), .RATIO(R)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
    .in_data_i(in_data), .in_last_i(in_last), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .out_data_o(out_data), .out_mask_o(out_mask), .out_last_o(out_last),
    .out_valid_o(out_valid), .out_ready_i(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    cur.delete();
    m_data  = 32'h0;
    m_mask  = 4'h0;
    m_last  = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic check_out();
    check("out_valid", {31'h0, out_valid}, {31'h0, m_valid});
    check("out_data",  out_data, m_data);
    check("out_mask",  {28'h0, out_mask}, {28'h0, m_mask});
    check("out_last",  {31'h0, out_last}, {31'h0, m_last});
  endtask

  // One clock: drive inputs, check ready, advance model at the edge, check outputs.
  task automatic cycle(input logic v, input logic [7:0] d, input logic l,
                       input logic ordy, input logic c);
    logic comp, exp_rdy, wx;
    int n;
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = ordy;
    clr       = c;
    #1;
    n       = cur.size();
    comp    = (n == R - 1) || l;
    exp_rdy = !c && (!(v && comp) || !m_valid || ordy);
    check("in_ready", {31'h0, in_ready}, {31'h0, exp_rdy});
    acc_flag = v && exp_rdy;
    @(posedge clk);
    wx = m_valid && ordy;
    if (c) begin
      cur.delete();
      m_valid = 1'b0;
    end else if (acc_flag && comp) begin
      m_data = 32'h0;
      for (int i = 0; i < n; i++) m_data[i*W +: W] = cur[i];
      m_data[n*W +: W] = d;
      m_mask  = 4'((1 << (n + 1)) - 1);
      m_last  = l;
      m_valid = 1'b1;
      cur.delete();
    end else begin
      if (acc_flag) cur.push_back(d);
      if (wx) m_valid = 1'b0;
    end
    #1;
    check_out();
  endtask

  task automatic send(input logic [7:0] d, input logic l, input logic ordy);
    for (int t = 0; t < 20; t++) begin
      cycle(1'b1, d, l, ordy, 1'b0);
      if (acc_flag) return;
    end
    check("accept_timeout", 32'h0, 32'h1);
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 8'h00, 1'b0, ordy, 1'b0);
  endtask

  initial begin
    logic       pend;
    logic [7:0] pd;
    logic       pl;
    logic       v, ordy, c;

    rst_n = 1'b0; clr = 1'b0; in_data = 8'h0; in_last = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    model_reset();
    #3;
    check_out();
    @(negedge clk);
    rst_n = 1'b1;

    // Four back-to-back beats form one full word.
    send(8'h11, 1'b0, 1'b1); send(8'h22, 1'b0, 1'b1);
    send(8'h33, 1'b0, 1'b1); send(8'h44, 1'b0, 1'b1);
    check("full_word", out_data, 32'h44332211);
    check("full_mask", {28'h0, out_mask}, 32'hF);
    idle(1'b1);
    check("full_valid_drop", {31'h0, out_valid}, 32'h0);

    // Early close with last, then the next beat starts at slot 0.
    send(8'hAA, 1'b0, 1'b1); send(8'hBB, 1'b1, 1'b1);
    check("short_word", out_data, 32'h0000BBAA);
    check("short_mask", {28'h0, out_mask}, 32'h3);
    send(8'h5A, 1'b1, 1'b1);
    check("single_word", out_data, 32'h0000005A);
    check("single_mask", {28'h0, out_mask}, 32'h1);
    check("single_last", {31'h0, out_last}, 32'h1);
    idle(1'b1);

    // Downstream stalls after the first word: only the 8th beat is held off.
    for (int i = 1; i <= 4; i++) send(8'(8'h80 + i), 1'b0, 1'b1);
    for (int i = 5; i <= 7; i++) send(8'(8'h80 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'h88, 1'b0, 1'b0, 1'b0);
    check("stall_hold", out_data, 32'h84838281);
    send(8'h88, 1'b0, 1'b1);
    check("second_word", out_data, 32'h88878685);
    idle(1'b1);

    // Clear discards a partial word.
    send(8'hE1, 1'b0, 1'b1); send(8'hE2, 1'b0, 1'b1);
    cycle(1'b1, 8'hE3, 1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b0, 1'b1);
    check("after_clr", out_data, 32'h04030201);
    idle(1'b1);

    // Asynchronous reset with a word pending and a partial word open.
    for (int i = 1; i <= 4; i++) send(8'(8'h10 * i), 1'b0, 1'b0);
    send(8'h55, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_out();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) send(8'(8'hC0 + i), 1'b0, 1'b1);
    check("after_rst", out_data, 32'hC4C3C2C1);
    idle(1'b1);

    // Random traffic; a refused beat is held until it is taken.
    pend = 1'b0; pd = 8'h0; pl = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      if (!pend) begin
        pend = ($urandom % 4) != 0;
        pd   = 8'($urandom);
        pl   = ($urandom % 6) == 0;
      end
      v    = pend;
      ordy = ($urandom % 3) != 0;
      c    = ($urandom % 64) == 0;
      cycle(v, pd, pl, ordy, c);
      if (acc_flag) pend = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
